// File: rtl/keypad_scan_mapper.sv
// Keypad front end: strobes active-low rows, samples synchronised active-low
// columns, debounces whole-frame results, remaps each press through a
// writable table and offers it on a valid/ready handshake.
module keypad_scan_mapper #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CODE_W   = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROWS-1:0]   row_n,
  input  logic [COLS-1:0]   col_n,
  input  logic              map_en,
  input  logic              map_we,
  input  logic [CODE_W-1:0] map_addr,
  input  logic [CODE_W-1:0] map_data,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int unsigned NumKeys = ROWS * COLS;
  localparam int unsigned DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned RowW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CntW    = $clog2(DEBOUNCE + 1);

  logic [COLS-1:0]   col_s1_q, col_s2_q;
  logic [DivW-1:0]   div_q, div_d;
  logic [RowW-1:0]   row_q, row_d;
  logic              hit_q, hit_d;
  logic [CODE_W-1:0] hit_code_q, hit_code_d;
  logic              last_vld_q, last_vld_d;
  logic [CODE_W-1:0] last_code_q, last_code_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              stable_vld_q, stable_vld_d;
  logic [CODE_W-1:0] stable_code_q, stable_code_d;
  logic              key_valid_q, key_valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              overflow_q, overflow_d;
  logic [CODE_W-1:0] table_q [NumKeys];
  logic [CODE_W-1:0] table_d [NumKeys];

  logic              row_end, frame_end, col_hit, res_vld, same, press, transfer;
  logic [CODE_W-1:0] row_code, res_code, mapped;
  logic [CntW-1:0]   cnt_next;
  int unsigned       col_idx;

  // Scan counters, first-hit capture within a frame, and the frame result.
  always_comb begin
    row_end   = (div_q == DivW'(SCAN_DIV - 1));
    frame_end = row_end && (row_q == RowW'(ROWS - 1));
    col_hit   = 1'b0;
    col_idx   = 0;
    // Descending loop so the lowest low column ends up winning.
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_s2_q[c]) begin
        col_hit = 1'b1;
        col_idx = c;
      end
    end
    row_code = CODE_W'(int'(row_q) * COLS + col_idx);
    div_d    = row_end ? '0 : div_q + DivW'(1);
    row_d    = row_q;
    if (row_end) row_d = (row_q == RowW'(ROWS - 1)) ? '0 : row_q + RowW'(1);
    hit_d      = hit_q;
    hit_code_d = hit_code_q;
    if (frame_end) begin
      hit_d = 1'b0;
    end else if (row_end && !hit_q && col_hit) begin
      hit_d      = 1'b1;
      hit_code_d = row_code;
    end
    res_vld  = hit_q || (row_end && col_hit);
    res_code = hit_q ? hit_code_q : row_code;
  end

  // Debounce: count identical frame results, promote to stable at DEBOUNCE.
  always_comb begin
    last_vld_d    = last_vld_q;
    last_code_d   = last_code_q;
    cnt_d         = cnt_q;
    stable_vld_d  = stable_vld_q;
    stable_code_d = stable_code_q;
    press         = 1'b0;
    same     = (res_vld == last_vld_q) && (!res_vld || (res_code == last_code_q));
    cnt_next = CntW'(1);
    if (same) cnt_next = (cnt_q == CntW'(DEBOUNCE)) ? cnt_q : cnt_q + CntW'(1);
    if (frame_end) begin
      last_vld_d  = res_vld;
      last_code_d = res_code;
      cnt_d       = cnt_next;
      if ((cnt_next >= CntW'(DEBOUNCE)) &&
          ((res_vld != stable_vld_q) || (res_vld && (res_code != stable_code_q)))) begin
        stable_vld_d  = res_vld;
        stable_code_d = res_code;
        press         = res_vld;
      end
    end
  end

  // Table lookup (pre-write contents), handshake, overflow and table writes.
  always_comb begin
    mapped      = map_en ? table_q[res_code] : res_code;
    transfer    = key_valid_q && key_ready;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overflow_d  = overflow_q && !overflow_clr;
    if (press) begin
      if (!key_valid_q || transfer) begin
        key_valid_d = 1'b1;
        key_code_d  = mapped;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (transfer) begin
      key_valid_d = 1'b0;
    end
    table_d = table_q;
    if (map_we && (32'(map_addr) < NumKeys)) table_d[map_addr] = map_data;
  end

  // State registers; reset restores the identity table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q      <= '1;
      col_s2_q      <= '1;
      div_q         <= '0;
      row_q         <= '0;
      hit_q         <= 1'b0;
      hit_code_q    <= '0;
      last_vld_q    <= 1'b0;
      last_code_q   <= '0;
      cnt_q         <= '0;
      stable_vld_q  <= 1'b0;
      stable_code_q <= '0;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      overflow_q    <= 1'b0;
      for (int i = 0; i < NumKeys; i++) table_q[i] <= CODE_W'(i);
    end else begin
      col_s1_q      <= col_n;
      col_s2_q      <= col_s1_q;
      div_q         <= div_d;
      row_q         <= row_d;
      hit_q         <= hit_d;
      hit_code_q    <= hit_code_d;
      last_vld_q    <= last_vld_d;
      last_code_q   <= last_code_d;
      cnt_q         <= cnt_d;
      stable_vld_q  <= stable_vld_d;
      stable_code_q <= stable_code_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      overflow_q    <= overflow_d;
      table_q       <= table_d;
    end
  end

  assign row_n     = ~(ROWS'(1) << row_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = stable_vld_q;
  assign overflow  = overflow_q;

endmodule
